// File: rtl/alu_74382_bist.sv
// Built-in self-test sequencer for the 74382-compatible ALU core: walks all 64 {sel, Cn, A, B} corner vectors.
// Optional ALU_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module alu_74382_bist #(
    parameter int OPERAND_W  = 4,
    parameter int RESULT_W   = 4,
    parameter int SELECT_W   = 3,
    parameter int SETTLE_CYC = 2,
    parameter int ERR_CNT_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [SELECT_W-1:0]   alu_sel,
    output logic [OPERAND_W-1:0]  alu_port_a,
    output logic [OPERAND_W-1:0]  alu_port_b,
    output logic                  alu_carry_in,
    input  logic [RESULT_W-1:0]   alu_result,
    input  logic                  alu_overflow,
    input  logic                  alu_carry_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  first_fail_vld,
    output logic [SELECT_W+2:0]   first_fail_idx
);

    localparam int V_W = SELECT_W + 3;
    localparam logic [V_W-1:0] V_LAST = '1;
    localparam logic [3:0] WAIT_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;
    typedef enum logic [1:0] {CLS_ZERO, CLS_ONES, CLS_ONES_LSB0, CLS_ZERO_LSB1} res_class_t;

    // Golden entry {class[1:0], overflow, carry_out}. Each op row packs 8 two-bit classes
    // (case 7 in the top bits) plus per-case overflow and carry masks.
    function automatic logic [3:0] rom_entry(input logic [V_W-1:0] v);
        logic [15:0] cls;
        logic [7:0]  ovf;
        logic [7:0]  cy;
        int          c;
        c = int'(v[2:0]);
        case (int'(v[V_W-1:3]))
            0:       begin cls = 16'h0000; ovf = 8'hFF; cy = 8'hFF; end  // CLEAR
            1:       begin cls = 16'h3449; ovf = 8'h00; cy = 8'hB2; end  // B minus A
            2:       begin cls = 16'h1C61; ovf = 8'h00; cy = 8'hD4; end  // A minus B
            3:       begin cls = 16'h4394; ovf = 8'h00; cy = 8'hE8; end  // A plus B
            4:       begin cls = 16'h1414; ovf = 8'h00; cy = 8'h00; end  // XOR
            5:       begin cls = 16'h5454; ovf = 8'h00; cy = 8'h00; end  // OR
            6:       begin cls = 16'h4040; ovf = 8'h88; cy = 8'h88; end  // AND
            7:       begin cls = 16'h5555; ovf = 8'hFF; cy = 8'hFF; end  // PRESET
            default: begin cls = 16'h0000; ovf = 8'h00; cy = 8'h00; end
        endcase
        return {cls[2*c +: 2], ovf[c], cy[c]};
    endfunction

    function automatic logic [RESULT_W-1:0] expand_class(input logic [1:0] cls);
        case (cls)
            CLS_ONES:      return '1;
            CLS_ONES_LSB0: return {{(RESULT_W-1){1'b1}}, 1'b0};
            CLS_ZERO_LSB1: return RESULT_W'(1);
            default:       return '0;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [V_W-1:0]         v_q, v_d;
    logic [3:0]             wait_q, wait_d;
    logic [SELECT_W-1:0]    sel_q, sel_d;
    logic [OPERAND_W-1:0]   a_q, a_d, b_q, b_d;
    logic                   cin_q, cin_d;
    logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic                   ffv_q, ffv_d;
    logic [V_W-1:0]         ffidx_q, ffidx_d;

    logic [3:0]             rom_q_entry;
    logic [RESULT_W+1:0]    expected;
    logic                   mismatch;

    assign rom_q_entry = rom_entry(v_q);
    assign expected    = {expand_class(rom_q_entry[3:2]), rom_q_entry[1], rom_q_entry[0]};
    assign mismatch    = ({alu_result, alu_overflow, alu_carry_out} != expected);

    // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        wait_d  = wait_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffidx_d = ffidx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    v_d     = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_DRIVE: begin
                sel_d   = v_q[V_W-1:3];
                cin_d   = v_q[2];
                a_d     = {OPERAND_W{v_q[1]}};
                b_d     = {OPERAND_W{v_q[0]}};
                wait_d  = 4'd0;
                state_d = (SETTLE_CYC == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_CNT_W'(1);
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffidx_d = v_q;
                    end
                end
                if (v_q == V_LAST || (STOP_ON_FAIL && mismatch)) begin
                    state_d = S_DONE;
                end else begin
                    v_d     = v_q + V_W'(1);
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            wait_q  <= '0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffidx_q <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            wait_q  <= wait_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffidx_q <= ffidx_d;
        end
    end

    assign alu_sel        = sel_q;
    assign alu_port_a     = a_q;
    assign alu_port_b     = b_q;
    assign alu_carry_in   = cin_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_idx = ffidx_q;

endmodule
